// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-side definitions: FSM states, command/response codes,
// default timing and the frame parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a clock
// falling-edge strobe. Also used by the PS/2 receiver.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_o
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;

  // Idle bus level is high, so the chains reset to 1 to avoid a false edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk_i};
      r_data_sync <= {r_data_sync[0], ps2_data_i};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign clk_s_o    = r_clk_sync[1];
  assign data_s_o   = r_data_sync[1];
  assign clk_fall_o = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift the
// frame on device clocks and check the device ACK, with an overall timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  input  logic [7:0] data_i,
  input  logic       send_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic w_clk_s, w_data_s, w_clk_fall;

  ps2_line_sync u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s_o    (w_clk_s),
    .data_s_o   (w_data_s),
    .clk_fall_o (w_clk_fall)
  );

  state_t        r_state;
  logic [7:0]    r_data;
  logic          r_par;
  logic [IW-1:0] r_inh;
  logic [TW-1:0] r_tmo;
  logic [3:0]    r_bitcnt;
  logic          r_clk_oe, r_data_oe, r_busy, r_done, r_err;
  logic          w_tmo_active;

  assign w_tmo_active = (r_state == S_SHIFT) || (r_state == S_ACK) ||
                        (r_state == S_WAIT_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_inh     <= '0;
      r_tmo     <= '0;
      r_bitcnt  <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // Timeout wins over any edge seen in the same cycle
      if (w_tmo_active && r_tmo == TMO_LAST) begin
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_err     <= 1'b1;
        r_busy    <= 1'b0;
        r_state   <= S_IDLE;
      end else begin
        if (w_tmo_active) r_tmo <= r_tmo + 1'b1;
        case (r_state)
          S_IDLE: begin
            // A pulse still showing means busy only just fell: skip this cycle
            if (send_i && !r_done && !r_err) begin
              r_data    <= data_i;
              r_par     <= odd_par(data_i);
              r_inh     <= '0;
              r_busy    <= 1'b1;
              r_clk_oe  <= 1'b1;
              r_data_oe <= 1'b0;
              r_state   <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (r_inh == INH_LAST) begin
              r_data_oe <= 1'b1;
              r_state   <= S_RTS;
            end else begin
              r_inh <= r_inh + 1'b1;
            end
          end
          S_RTS: begin
            r_clk_oe <= 1'b0;
            r_tmo    <= '0;
            r_bitcnt <= '0;
            r_state  <= S_SHIFT;
          end
          S_SHIFT: begin
            if (w_clk_fall) begin
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt < 4'd8) begin
                r_data_oe <= ~r_data[r_bitcnt[2:0]];
              end else if (r_bitcnt == 4'd8) begin
                r_data_oe <= ~r_par;
              end else begin
                r_data_oe <= 1'b0;
                r_state   <= S_ACK;
              end
            end
          end
          S_ACK: begin
            if (w_clk_fall) begin
              r_bitcnt <= r_bitcnt + 1'b1;
              if (!w_data_s) begin
                r_state <= S_WAIT_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (w_clk_s && w_data_s) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe_o  = r_clk_oe;
  assign ps2_data_oe_o = r_data_oe;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM on open-drain lines, scoreboard of
// expected frames and done/err outcomes.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       send_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_oe_o, ps2_data_oe_o, busy_o, done_o, err_o;
  logic       w_clk_line, w_data_line;

  int n_chk = 0;
  int n_pass = 0;

  logic [10:0] exp_frame_q[$];
  logic [2:0]  exp_out_q[$];
  logic [2:0]  got_out_q[$];

  assign w_clk_line  = dev_clk & ~ps2_clk_oe_o;
  assign w_data_line = dev_data & ~ps2_data_oe_o;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ps2_clk_i     (w_clk_line),
    .ps2_data_i    (w_data_line),
    .ps2_clk_oe_o  (ps2_clk_oe_o),
    .ps2_data_oe_o (ps2_data_oe_o),
    .data_i        (data_i),
    .send_i        (send_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  // Outcome monitor: {busy, err, done} in every cycle a pulse is seen
  always @(negedge clk)
    if (!rst_i && (done_o || err_o)) got_out_q.push_back({busy_o, err_o, done_o});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_exp(input logic [7:0] d, input logic [2:0] o);
    exp_frame_q.push_back({1'b1, ~^d, d, 1'b0});
    exp_out_q.push_back(o);
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    data_i = d;
    send_i = 1'b1;
    @(negedge clk);
    send_i = 1'b0;
  endtask

  // Device BFM: waits for RTS, checks start, clocks 10 bits, optional ACK
  task automatic dev_frame(input bit ack, output logic [10:0] bits, output bit ok);
    int t;
    ok = 1'b1;
    bits = '0;
    t = 0;
    while (!(ps2_clk_oe_o == 1'b0 && ps2_data_oe_o == 1'b1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      ok = 1'b0;
      return;
    end
    repeat (10) @(negedge clk);
    bits[0] = w_data_line;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      bits[k] = w_data_line;
      repeat (20) @(negedge clk);
    end
    if (ack) dev_data = 1'b0;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_data = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ps2_clk_oe_o, ps2_data_oe_o, busy_o, done_o, err_o} !== 5'b0)
      $display("FAIL reset_outputs got %b exp 00000",
               {ps2_clk_oe_o, ps2_data_oe_o, busy_o, done_o, err_o});
    else n_pass++;
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_ed();
    logic [10:0] bits, ef;
    logic [2:0]  eo, go;
    bit ok;
    int n;
    push_exp(8'hED, 3'b001);
    send_byte(8'hED);
    n_chk++;
    if (busy_o !== 1'b1) $display("FAIL ed_busy got %b exp 1", busy_o); else n_pass++;
    n = 0;
    while (ps2_clk_oe_o === 1'b1 && ps2_data_oe_o === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_chk++;
    if (n != INH) $display("FAIL ed_inhibit_len got %0d exp %0d", n, INH); else n_pass++;
    n_chk++;
    if ({ps2_clk_oe_o, ps2_data_oe_o} !== 2'b11)
      $display("FAIL ed_rts got %b exp 11", {ps2_clk_oe_o, ps2_data_oe_o});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({ps2_clk_oe_o, ps2_data_oe_o} !== 2'b01)
      $display("FAIL ed_clk_release got %b exp 01", {ps2_clk_oe_o, ps2_data_oe_o});
    else n_pass++;
    dev_frame(1'b1, bits, ok);
    repeat (20) @(negedge clk);
    ef = exp_frame_q.pop_front();
    n_chk++;
    if (!ok || bits !== ef) $display("FAIL ed_frame got %b exp %b", bits, ef); else n_pass++;
    eo = exp_out_q.pop_front();
    go = (got_out_q.size() != 0) ? got_out_q.pop_front() : 3'b111;
    n_chk++;
    if (go !== eo || got_out_q.size() != 0)
      $display("FAIL ed_outcome got %b exp %b", go, eo);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits1, bits2, ef;
    logic [2:0]  eo, go;
    bit ok1, ok2;
    push_exp(8'h01, 3'b001);
    send_byte(8'h01);
    fork
      dev_frame(1'b1, bits1, ok1);
      begin
        int t;
        t = 0;
        while (done_o !== 1'b1 && t < 3000) begin
          @(negedge clk);
          t++;
        end
        data_i = 8'hF4;
        send_i = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy_o !== 1'b0) $display("FAIL b2b_ignored_on_fall got %b exp 0", busy_o);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (busy_o !== 1'b1) $display("FAIL b2b_accepted got %b exp 1", busy_o);
        else n_pass++;
        send_i = 1'b0;
        push_exp(8'hF4, 3'b001);
      end
    join
    ef = exp_frame_q.pop_front();
    n_chk++;
    if (!ok1 || bits1 !== ef) $display("FAIL b2b_frame01 got %b exp %b", bits1, ef);
    else n_pass++;
    eo = exp_out_q.pop_front();
    go = (got_out_q.size() != 0) ? got_out_q.pop_front() : 3'b111;
    n_chk++;
    if (go !== eo) $display("FAIL b2b_outcome01 got %b exp %b", go, eo); else n_pass++;
    dev_frame(1'b1, bits2, ok2);
    repeat (20) @(negedge clk);
    ef = exp_frame_q.pop_front();
    n_chk++;
    if (!ok2 || bits2 !== ef) $display("FAIL b2b_frameF4 got %b exp %b", bits2, ef);
    else n_pass++;
    eo = exp_out_q.pop_front();
    go = (got_out_q.size() != 0) ? got_out_q.pop_front() : 3'b111;
    n_chk++;
    if (go !== eo || got_out_q.size() != 0)
      $display("FAIL b2b_outcomeF4 got %b exp %b", go, eo);
    else n_pass++;
  endtask

  task automatic test_no_ack();
    logic [10:0] bits, ef;
    logic [2:0]  eo, go;
    bit ok;
    push_exp(8'hFF, 3'b010);
    send_byte(8'hFF);
    dev_frame(1'b0, bits, ok);
    repeat (20) @(negedge clk);
    ef = exp_frame_q.pop_front();
    n_chk++;
    if (!ok || bits !== ef) $display("FAIL noack_frame got %b exp %b", bits, ef); else n_pass++;
    eo = exp_out_q.pop_front();
    go = (got_out_q.size() != 0) ? got_out_q.pop_front() : 3'b111;
    n_chk++;
    if (go !== eo || got_out_q.size() != 0)
      $display("FAIL noack_outcome got %b exp %b", go, eo);
    else n_pass++;
    n_chk++;
    if ({ps2_clk_oe_o, ps2_data_oe_o, busy_o} !== 3'b000)
      $display("FAIL noack_released got %b exp 000", {ps2_clk_oe_o, ps2_data_oe_o, busy_o});
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [2:0] go;
    int t, n;
    exp_out_q.push_back(3'b010);
    send_byte(8'hF4);
    t = 0;
    while (ps2_clk_oe_o === 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (err_o !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n != TMO) $display("FAIL timeout_len got %0d exp %0d", n, TMO); else n_pass++;
    n_chk++;
    if ({ps2_clk_oe_o, ps2_data_oe_o} !== 2'b00)
      $display("FAIL timeout_release got %b exp 00", {ps2_clk_oe_o, ps2_data_oe_o});
    else n_pass++;
    repeat (5) @(negedge clk);
    go = (got_out_q.size() != 0) ? got_out_q.pop_front() : 3'b111;
    n_chk++;
    if (go !== exp_out_q[0] || got_out_q.size() != 0)
      $display("FAIL timeout_outcome got %b exp %b", go, exp_out_q[0]);
    else n_pass++;
    void'(exp_out_q.pop_front());
  endtask

  task automatic test_send_ignored();
    logic [10:0] bits, ef;
    logic [2:0]  eo, go;
    bit ok;
    push_exp(8'hED, 3'b001);
    send_byte(8'hED);
    fork
      dev_frame(1'b1, bits, ok);
      begin
        repeat (150) @(negedge clk);
        data_i = 8'hAA;
        send_i = 1'b1;
        @(negedge clk);
        send_i = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    ef = exp_frame_q.pop_front();
    n_chk++;
    if (!ok || bits !== ef) $display("FAIL ignore_frame got %b exp %b", bits, ef); else n_pass++;
    eo = exp_out_q.pop_front();
    go = (got_out_q.size() != 0) ? got_out_q.pop_front() : 3'b111;
    n_chk++;
    if (go !== eo || got_out_q.size() != 0)
      $display("FAIL ignore_outcome got %b exp %b", go, eo);
    else n_pass++;
    n_chk++;
    if (busy_o !== 1'b0) $display("FAIL ignore_not_queued got %b exp 0", busy_o); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [10:0] bits, ef;
    logic [2:0]  eo, go;
    bit ok;
    int t;
    send_byte(8'hED);
    t = 0;
    while (!(ps2_clk_oe_o === 1'b0 && ps2_data_oe_o === 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      if (k < 5) begin
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
      end
    end
    n_chk++;
    if (ps2_data_oe_o !== 1'b1) $display("FAIL rst_pre_d4 got %b exp 1", ps2_data_oe_o);
    else n_pass++;
    rst_i = 1'b1;
    #1;
    n_chk++;
    if ({ps2_clk_oe_o, ps2_data_oe_o, busy_o} !== 3'b000)
      $display("FAIL rst_async got %b exp 000", {ps2_clk_oe_o, ps2_data_oe_o, busy_o});
    else n_pass++;
    @(negedge clk);
    dev_clk = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (got_out_q.size() != 0) $display("FAIL rst_no_pulse got %0d exp 0", got_out_q.size());
    else n_pass++;
    push_exp(8'hED, 3'b001);
    send_byte(8'hED);
    n_chk++;
    if ({ps2_clk_oe_o, ps2_data_oe_o, busy_o} !== 3'b101)
      $display("FAIL rst_restart_inhibit got %b exp 101", {ps2_clk_oe_o, ps2_data_oe_o, busy_o});
    else n_pass++;
    dev_frame(1'b1, bits, ok);
    repeat (20) @(negedge clk);
    ef = exp_frame_q.pop_front();
    n_chk++;
    if (!ok || bits !== ef) $display("FAIL rst_frame got %b exp %b", bits, ef); else n_pass++;
    eo = exp_out_q.pop_front();
    go = (got_out_q.size() != 0) ? got_out_q.pop_front() : 3'b111;
    n_chk++;
    if (go !== eo || got_out_q.size() != 0)
      $display("FAIL rst_outcome got %b exp %b", go, eo);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_no_ack();
    test_timeout();
    test_send_ignored();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
